// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - shared MD5 types, constants and round constant table
package md5_pkg;

    typedef enum logic [2:0] {
        ST_DATA,
        ST_PAD,
        ST_ZERO,
        ST_LEN_LO,
        ST_LEN_HI
    } pad_state_t;

    localparam logic [7:0] MD5_PAD_BYTE      = 8'h80;
    localparam logic [4:0] MD5_WORDS_PER_BLK = 5'd16;
    localparam logic [3:0] MD5_LEN_IDX       = 4'd14;

    // T[i] = floor(abs(sin(i+1)) * 2^32), consumed by the round datapath
    localparam logic [31:0] MD5_T [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    function automatic logic [31:0] md5_t(input logic [5:0] i);
        return MD5_T[i];
    endfunction

endpackage

// File: rtl/md5_msg_padder.sv
// rtl/md5_msg_padder.sv - byte stream to padded little-endian MD5 message words
// Optional block counter output enabled by MD5_PAD_STATS_EN.
module md5_msg_padder
    import md5_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic        in_empty,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [3:0]  out_idx,
    output logic        out_blk_last
`ifdef MD5_PAD_STATS_EN
    ,
    output logic [31:0] blk_count
`endif
);

    pad_state_t  state;
    pad_state_t  next_after_pad;
    logic [31:0] part;
    logic [1:0]  pos;
    logic [3:0]  widx;
    logic [63:0] bit_len;

    logic        can_load;
    logic        accept;
    logic        is_empty;
    logic        load_en;
    logic        load_last;
    logic [31:0] load_word;
    logic [31:0] data_shift;
    logic [31:0] pad_shift;
    logic [31:0] merged_word;
    logic [2:0]  pad_pos;

    // A byte that finishes a word needs room in the holding register; others never stall.
    assign in_ready = !rst && (state == ST_DATA) &&
                      (can_load || (pos != 2'd3 && !in_last));

    always_comb begin
        can_load    = !out_valid || out_ready;
        accept      = in_valid && in_ready;
        is_empty    = in_last && in_empty;
        data_shift  = is_empty ? 32'd0 : ({24'd0, in_data} << {pos, 3'b000});
        pad_pos     = {1'b0, pos} + {2'b00, !is_empty};
        pad_shift   = pad_pos[2] ? 32'd0 : ({24'd0, MD5_PAD_BYTE} << {pad_pos[1:0], 3'b000});
        merged_word = part | data_shift | (in_last ? pad_shift : 32'd0);
        next_after_pad = (widx == MD5_LEN_IDX - 4'd1) ? ST_LEN_LO : ST_ZERO;

        load_en   = 1'b0;
        load_word = 32'd0;
        load_last = 1'b0;
        case (state)
            ST_DATA: begin
                load_en   = accept && (in_last || pos == 2'd3);
                load_word = merged_word;
            end
            ST_PAD: begin
                load_en   = can_load;
                load_word = {24'd0, MD5_PAD_BYTE};
            end
            ST_ZERO: begin
                load_en = can_load;
            end
            ST_LEN_LO: begin
                load_en   = can_load;
                load_word = bit_len[31:0];
            end
            ST_LEN_HI: begin
                // Word 15 is loaded once, then the state waits for it to be taken.
                load_en   = can_load && !out_blk_last;
                load_word = bit_len[63:32];
                load_last = 1'b1;
            end
            default: begin
                load_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_DATA;
            part         <= 32'd0;
            pos          <= 2'd0;
            widx         <= 4'd0;
            bit_len      <= 64'd0;
            out_valid    <= 1'b0;
            out_word     <= 32'd0;
            out_idx      <= 4'd0;
            out_blk_last <= 1'b0;
        end else begin
            if (load_en) begin
                out_valid    <= 1'b1;
                out_word     <= load_word;
                out_idx      <= widx;
                out_blk_last <= load_last;
                widx         <= widx + 4'd1;
            end else if (out_valid && out_ready) begin
                out_valid    <= 1'b0;
                out_blk_last <= 1'b0;
            end

            case (state)
                ST_DATA: begin
                    if (accept) begin
                        if (!is_empty) begin
                            bit_len <= bit_len + 64'd8;
                        end
                        if (in_last || pos == 2'd3) begin
                            part <= 32'd0;
                            pos  <= 2'd0;
                        end else begin
                            part <= part | data_shift;
                            pos  <= pos + 2'd1;
                        end
                        if (in_last) begin
                            state <= (pos == 2'd3 && !is_empty) ? ST_PAD : next_after_pad;
                        end
                    end
                end
                ST_PAD: begin
                    if (load_en) begin
                        state <= next_after_pad;
                    end
                end
                ST_ZERO: begin
                    // Zero fill wraps through index 15 into a second block when needed.
                    if (load_en && widx == MD5_LEN_IDX - 4'd1) begin
                        state <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (load_en) begin
                        state <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (out_valid && out_blk_last && out_ready) begin
                        state   <= ST_DATA;
                        bit_len <= 64'd0;
                        part    <= 32'd0;
                        pos     <= 2'd0;
                    end
                end
                default: begin
                    state <= ST_DATA;
                end
            endcase
        end
    end

`ifdef MD5_PAD_STATS_EN
    localparam logic [3:0] LAST_IDX = 4'(MD5_WORDS_PER_BLK - 5'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_count <= 32'd0;
        end else if (out_valid && out_ready && out_idx == LAST_IDX) begin
            blk_count <= blk_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_md5_msg_padder.sv
// tb/tb_md5_msg_padder.sv - self-checking bench for md5_msg_padder
module tb_md5_msg_padder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        in_last = 1'b0;
    logic        in_empty = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_word;
    logic [3:0]  out_idx;
    logic        out_blk_last;

    md5_msg_padder dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_empty     (in_empty),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_word     (out_word),
        .out_idx      (out_idx),
        .out_blk_last (out_blk_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [3:0]  idx;
        logic        last;
    } out_t;

    typedef struct {
        int          len;
        logic [7:0]  fill;
        logic [7:0]  inc;
        int          total;
        int          sel;
        logic [31:0] exp;
        logic        last;
    } vec_t;

    out_t       got_q[$];
    out_t       exp_q[$];
    logic [7:0] msg_q[$];
    vec_t       vecs[$];

    int n_assert = 0;
    int n_fail   = 0;
    int ready_mode = 0;

    logic        stall_prev = 1'b0;
    logic [31:0] prev_word;
    logic [3:0]  prev_idx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Output collector plus hold-stability check while back-pressured.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_stable", {27'd0, out_valid, out_idx, out_word},
                    {27'd0, 1'b1, prev_idx, prev_word});
            end
            if (out_valid && out_ready) begin
                got_q.push_back('{out_word, out_idx, out_blk_last});
            end
            stall_prev = out_valid && !out_ready;
            prev_word  = out_word;
            prev_idx   = out_idx;
        end
    end

    // Reference: standard MD5 padding on a byte array, then little-endian word split.
    task automatic build_expected();
        logic [7:0]      b[$];
        longint unsigned bits;
        int              nw;
        b    = msg_q;
        bits = 64'(msg_q.size()) * 64'd8;
        b.push_back(8'h80);
        while (b.size() % 64 != 56) b.push_back(8'h00);
        for (int i = 0; i < 8; i++) b.push_back(8'(bits >> (8 * i)));
        nw = b.size() / 4;
        exp_q.delete();
        for (int w = 0; w < nw; w++) begin
            exp_q.push_back('{{b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]}, 4'(w % 16), (w == nw - 1)});
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input logic empty);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_empty = empty;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
            if (guard > 500) begin
                chk("in_ready_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
    endtask

    task automatic send_msg(input bit gaps);
        if (msg_q.size() == 0) begin
            send_byte(8'($urandom), 1'b1, 1'b1);
        end else begin
            for (int i = 0; i < msg_q.size(); i++) begin
                send_byte(msg_q[i], (i == msg_q.size() - 1), 1'b0);
                if (gaps && $urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic check_message(input string tag);
        int guard = 0;
        while (got_q.size() < exp_q.size() && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk($sformatf("%s word_count", tag), 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s w%0d", tag, i),
                {27'd0, got_q[i].last, got_q[i].idx, got_q[i].word},
                {27'd0, exp_q[i].last, exp_q[i].idx, exp_q[i].word});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{6,  8'h61, 8'h00, 16, 0,  32'h61616161, 1'b0});
        vecs.push_back('{6,  8'h61, 8'h00, 16, 1,  32'h00806161, 1'b0});
        vecs.push_back('{6,  8'h61, 8'h00, 16, 13, 32'h00000000, 1'b0});
        vecs.push_back('{6,  8'h61, 8'h00, 16, 14, 32'h00000030, 1'b0});
        vecs.push_back('{6,  8'h61, 8'h00, 16, 15, 32'h00000000, 1'b1});
        vecs.push_back('{0,  8'h00, 8'h00, 16, 0,  32'h00000080, 1'b0});
        vecs.push_back('{0,  8'h00, 8'h00, 16, 15, 32'h00000000, 1'b1});
        vecs.push_back('{4,  8'h61, 8'h01, 16, 0,  32'h64636261, 1'b0});
        vecs.push_back('{4,  8'h61, 8'h01, 16, 1,  32'h00000080, 1'b0});
        vecs.push_back('{4,  8'h61, 8'h01, 16, 14, 32'h00000020, 1'b0});
        vecs.push_back('{3,  8'h61, 8'h01, 16, 0,  32'h80636261, 1'b0});
        vecs.push_back('{7,  8'h00, 8'h01, 16, 1,  32'h80060504, 1'b0});
        vecs.push_back('{55, 8'h61, 8'h00, 16, 13, 32'h80616161, 1'b0});
        vecs.push_back('{55, 8'h61, 8'h00, 16, 14, 32'h000001B8, 1'b0});
        vecs.push_back('{56, 8'h61, 8'h00, 32, 13, 32'h61616161, 1'b0});
        vecs.push_back('{56, 8'h61, 8'h00, 32, 14, 32'h00000080, 1'b0});
        vecs.push_back('{56, 8'h61, 8'h00, 32, 15, 32'h00000000, 1'b0});
        vecs.push_back('{56, 8'h61, 8'h00, 32, 30, 32'h000001C0, 1'b0});
        vecs.push_back('{56, 8'h61, 8'h00, 32, 31, 32'h00000000, 1'b1});
        vecs.push_back('{60, 8'h00, 8'h01, 32, 14, 32'h3B3A3938, 1'b0});
        vecs.push_back('{60, 8'h00, 8'h01, 32, 15, 32'h00000080, 1'b0});
        vecs.push_back('{60, 8'h00, 8'h01, 32, 30, 32'h000001E0, 1'b0});
        vecs.push_back('{64, 8'h00, 8'h01, 32, 16, 32'h00000080, 1'b0});
        vecs.push_back('{64, 8'h00, 8'h01, 32, 30, 32'h00000200, 1'b0});

        // Reset values, then in_ready on the first cycle out of reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst out_valid",    64'(out_valid),    64'd0);
        chk("rst in_ready",     64'(in_ready),     64'd0);
        chk("rst out_word",     64'(out_word),     64'd0);
        chk("rst out_idx",      64'(out_idx),      64'd0);
        chk("rst out_blk_last", 64'(out_blk_last), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready after rst", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        foreach (vecs[v]) begin
            msg_q.delete();
            for (int i = 0; i < vecs[v].len; i++) msg_q.push_back(8'(vecs[v].fill + vecs[v].inc * i));
            send_msg(1'b0);
            build_expected();
            check_message($sformatf("vec%0d", v));
            chk($sformatf("vec%0d total", v), 64'(got_q.size()), 64'(vecs[v].total));
            if (vecs[v].sel < got_q.size()) begin
                chk($sformatf("vec%0d sel%0d", v, vecs[v].sel),
                    {27'd0, got_q[vecs[v].sel].last, got_q[vecs[v].sel].idx, got_q[vecs[v].sel].word},
                    {27'd0, vecs[v].last, 4'(vecs[v].sel % 16), vecs[v].exp});
            end
            got_q.delete();
        end

        // Back-pressure mid-stream: word held, in_ready drops on the completing byte.
        msg_q.delete();
        for (int i = 0; i < 12; i++) msg_q.push_back(8'(8'h10 + i));
        ready_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send_byte(msg_q[i], 1'b0, 1'b0);
        chk("latency out_valid", 64'(out_valid), 64'd1);
        chk("latency out_word",  64'(out_word),  64'h13121110);
        chk("latency out_idx",   64'(out_idx),   64'd0);
        for (int i = 4; i < 7; i++) send_byte(msg_q[i], 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = msg_q[7];
        repeat (2) begin
            @(negedge clk);
            chk("stall in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        ready_mode = 0;
        for (int i = 7; i < 12; i++) send_byte(msg_q[i], (i == 11), 1'b0);
        build_expected();
        check_message("stall");
        got_q.delete();

        // Reset in the middle of a message discards it.
        for (int i = 0; i < 3; i++) send_byte(8'(8'h41 + i), 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid out_valid", 64'(out_valid), 64'd0);
        msg_q.delete();
        for (int i = 0; i < 6; i++) msg_q.push_back(8'h61);
        send_msg(1'b0);
        build_expected();
        check_message("rst_mid");
        chk("rst_mid w1", 64'(got_q.size() > 1 ? got_q[1].word : 32'hDEADBEEF), 64'h00806161);
        got_q.delete();

        // Random messages, random gaps and random back-pressure.
        ready_mode = 1;
        for (int m = 0; m < 25; m++) begin
            msg_q.delete();
            for (int i = 0; i < int'($urandom_range(0, 140)); i++) msg_q.push_back(8'($urandom));
            send_msg(1'b1);
            build_expected();
            check_message($sformatf("rand%0d", m));
            got_q.delete();
        end
        ready_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
